// File: rtl/uart_tx_dev.sv
// uart_tx_dev: memory-mapped UART transmitter. A small TX FIFO feeds an 8N1 serializer;
// DONE (and IRQ when IM is set) flags that a transmit burst has drained.
// Optional parity bit (CTRL bit2 = PODD, 8-data + parity frame) when UART_TX_PARITY_EN
// is defined; the default build is plain 8N1.
module uart_tx_dev #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [15:0] DIV_RESET  = 16'd15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [29:0] Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        tx,
   output logic        IRQ
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;
`ifdef UART_TX_PARITY_EN
   localparam bit ParityEn = 1'b1;
`else
   localparam bit ParityEn = 1'b0;
`endif

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e            state_q, state_d;
   logic [2:0]        ctrl_q, ctrl_d;
   logic [15:0]       div_q, div_d;
   logic [PtrW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CntW-1:0]   count_q, count_d;
   logic              ovf_q, ovf_d, done_q, done_d;
   logic [7:0]        shift_q, shift_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic [15:0]       baud_cnt_q, baud_cnt_d;
   logic              par_q, par_d, tx_q, tx_d, irq_q, irq_d;
   logic [7:0]        mem_q [FIFO_DEPTH];

   logic              wr_ctrl, wr_baud, wr_txdata, wr_status;
   logic              empty, full, busy, boundary, push, pop, done_set, ovf_set;
   logic [7:0]        head;
   logic [31:0]       count_w;
   logic [2:0]        cnt_field;
   logic              unused_bits;

   assign unused_bits = ^{Addr[29:2], Din[31:16]};
   assign head        = mem_q[rptr_q];
   assign empty       = (count_q == '0);
   assign full        = (count_q == CntW'(FIFO_DEPTH));
   assign busy        = (state_q != StIdle);
   assign boundary    = (baud_cnt_q == 16'd0);
   assign count_w     = 32'(count_q);
   assign cnt_field   = (count_w > 32'd7) ? 3'd7 : count_w[2:0];
   assign tx          = tx_q;
   assign IRQ         = irq_q;

   // Register decode, FIFO bookkeeping and serializer next state.
   always_comb begin
      wr_ctrl    = WE && (Addr[1:0] == 2'd0);
      wr_baud    = WE && (Addr[1:0] == 2'd1);
      wr_txdata  = WE && (Addr[1:0] == 2'd2);
      wr_status  = WE && (Addr[1:0] == 2'd3);
      state_d    = state_q;
      ctrl_d     = ctrl_q;
      div_d      = div_q;
      shift_d    = shift_q;
      bit_idx_d  = bit_idx_q;
      baud_cnt_d = baud_cnt_q;
      par_d      = par_q;
      pop        = 1'b0;
      done_set   = 1'b0;

      // Bit timer runs only while a frame is on the line; reload picks up the current DIV.
      if (state_q != StIdle) begin
         baud_cnt_d = boundary ? div_q : baud_cnt_q - 16'd1;
      end

      case (state_q)
         StIdle: begin
            if (ctrl_q[0] && !empty) begin
               pop        = 1'b1;
               state_d    = StStart;
               baud_cnt_d = div_q;
            end
         end
         StStart: begin
            if (boundary) begin
               state_d   = StData;
               bit_idx_d = 3'd0;
            end
         end
         StData: begin
            if (boundary) begin
               shift_d = shift_q >> 1;
               if (bit_idx_q == 3'd7) begin
                  state_d = ParityEn ? StParity : StStop;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         StParity: begin
            if (boundary) state_d = StStop;
         end
         StStop: begin
            if (boundary) begin
               if (ctrl_q[0] && !empty) begin
                  pop     = 1'b1;
                  state_d = StStart;
               end else begin
                  state_d  = StIdle;
                  done_set = empty;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (pop) begin
         shift_d = head;
         par_d   = (^head) ^ ctrl_q[2];
      end

      // A push is accepted when full only if the head leaves in the same cycle.
      push    = wr_txdata && (!full || pop);
      ovf_set = wr_txdata && full && !pop;
      wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
      rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (wr_ctrl) ctrl_d = {ParityEn ? Din[2] : 1'b0, Din[1:0]};
      if (wr_baud) div_d = Din[15:0];

      // Clearing writes win over a simultaneous set.
      ovf_d  = wr_status ? 1'b0 : (ovf_set ? 1'b1 : ovf_q);
      done_d = (wr_txdata || wr_status) ? 1'b0 : (done_set ? 1'b1 : done_q);

      case (state_d)
         StStart:  tx_d = 1'b0;
         StData:   tx_d = shift_d[0];
         StParity: tx_d = par_d;
         default:  tx_d = 1'b1;
      endcase

      irq_d = ctrl_q[1] & done_q;
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= StIdle;
         ctrl_q     <= 3'd0;
         div_q      <= DIV_RESET;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         done_q     <= 1'b0;
         shift_q    <= 8'd0;
         bit_idx_q  <= 3'd0;
         baud_cnt_q <= 16'd0;
         par_q      <= 1'b0;
         tx_q       <= 1'b1;
         irq_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ctrl_q     <= ctrl_d;
         div_q      <= div_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         done_q     <= done_d;
         shift_q    <= shift_d;
         bit_idx_q  <= bit_idx_d;
         baud_cnt_q <= baud_cnt_d;
         par_q      <= par_d;
         tx_q       <= tx_d;
         irq_q      <= irq_d;
      end
   end

   // FIFO storage; contents need no reset since the pointers define validity.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= Din[7:0];
   end

   // Read mux, combinational on Addr.
   always_comb begin
      Dout = 32'd0;
      case (Addr[1:0])
         2'd0:    Dout[2:0]  = ctrl_q;
         2'd1:    Dout[15:0] = div_q;
         2'd3:    Dout[7:0]  = {cnt_field, done_q, ovf_q, busy, full, empty};
         default: Dout       = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_dev.sv
// Scoreboard bench for uart_tx_dev: expected frames (per-cycle tx waveforms) and register
// reads are queued by the stimulus thread and checked by independent monitors.
module tb_uart_tx_dev;

`ifdef UART_TX_PARITY_EN
   localparam bit PEN = 1'b1;
`else
   localparam bit PEN = 1'b0;
`endif
   localparam int NB = PEN ? 11 : 10;

   localparam logic [1:0] A_CTRL = 2'd0, A_BAUD = 2'd1, A_TXD = 2'd2, A_STAT = 2'd3;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [29:0] Addr = '0;
   logic        WE = 1'b0;
   logic [31:0] Din = '0;
   logic [31:0] Dout;
   logic        tx, IRQ;

   uart_tx_dev #(.FIFO_DEPTH(4), .DIV_RESET(16'd15)) dut (
      .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din),
      .Dout(Dout), .tx(tx), .IRQ(IRQ)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [511:0] w;
      int           len;
      int           start;
      bit           b2b;
   } frame_t;

   typedef struct {
      logic [31:0] v;
      string       nm;
   } rd_t;

   frame_t fq[$];
   rd_t    rq[$];
   int     n_cmp = 0;
   int     n_fail = 0;
   bit     mon_en = 1'b0;
   bit     mon_busy = 1'b0;
   logic   rd_v = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   // Expected tx waveform: bits [0,chg) last p0 cycles, the rest p1 cycles.
   function automatic frame_t mk(input logic [7:0] d, input bit podd, input int p0,
                                 input int chg, input int p1, input int st, input bit b2b);
      frame_t f;
      logic [10:0] bv;
      bv = '1;
      bv[0] = 1'b0;
      for (int i = 0; i < 8; i++) bv[i+1] = d[i];
      if (PEN) bv[9] = (^d) ^ podd;
      f.w = '0;
      f.len = 0;
      for (int k = 0; k < NB; k++) begin
         for (int j = 0; j < ((k < chg) ? p0 : p1); j++) begin
            f.w[f.len] = bv[k];
            f.len++;
         end
      end
      f.start = st;
      f.b2b = b2b;
      return f;
   endfunction

   // Drive at posedge+1; returns the cycle number of the edge that applied the write.
   task automatic wr(input logic [1:0] a, input logic [31:0] d, output int e);
      Addr = {28'd0, a};
      Din = d;
      WE = 1'b1;
      @(posedge clk);
      #1;
      WE = 1'b0;
      e = cyc;
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
      rd_t r;
      r.v = exp;
      r.nm = nm;
      rq.push_back(r);
      Addr = {28'd0, a};
      rd_v = 1'b1;
      @(posedge clk);
      #1;
      rd_v = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (fq.size() == 0 && !mon_busy) return;
         tick(1);
      end
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d frames still pending, want 0", fq.size());
      fq.delete();
   endtask

   // Read monitor.
   initial begin
      rd_t r;
      forever begin
         @(negedge clk);
         if (rd_v) begin
            if (rq.size() == 0) begin
               chk("rd_queue", 32'd0, 32'd1);
            end else begin
               r = rq.pop_front();
               chk(r.nm, Dout, r.v);
            end
         end
      end
   end

   // Frame monitor: compares every cycle of each frame against the queued waveform.
   initial begin
      frame_t f;
      int st, bad, prev_end;
      prev_end = -100;
      forever begin
         @(negedge clk);
         if (mon_en && tx === 1'b0) begin
            if (fq.size() == 0) begin
               chk("frame_unexpected", 32'd1, 32'd0);
               for (int i = 0; i < 300 && tx === 1'b0; i++) @(negedge clk);
            end else begin
               mon_busy = 1'b1;
               f = fq.pop_front();
               st = cyc;
               bad = -1;
               for (int i = 0; i < f.len; i++) begin
                  if (i > 0) @(negedge clk);
                  if (tx !== f.w[i] && bad < 0) bad = i;
               end
               chk("frame_wave_first_bad_cycle", bad, -1);
               if (f.start >= 0) chk("frame_start_cycle", st, f.start);
               if (f.b2b) chk("frame_b2b_gap", st, prev_end + 1);
               prev_end = cyc;
               mon_busy = 1'b0;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, want finish");
      $fatal(1);
   end

   initial begin
      int e, w;
      reset = 1'b0;
      tick(3);
      reset = 1'b1;

      // Reset state.
      rd(A_STAT, 32'h01, "rst_status");
      rd(A_BAUD, 32'h0F, "rst_baud");
      rd(A_CTRL, 32'h00, "rst_ctrl");
      chk("rst_irq", IRQ, 1'b0);
      chk("rst_tx", tx, 1'b1);

      // Register masking.
      wr(A_CTRL, 32'hFFFF_FFFF, e);
      rd(A_CTRL, PEN ? 32'h7 : 32'h3, "ctrl_mask");
      wr(A_BAUD, 32'hFFFF_1234, e);
      rd(A_BAUD, 32'h1234, "baud_mask");
      rd(A_TXD, 32'h0, "txdata_reads0");

      // Reset mid-frame (DIV=15, byte 0x00 keeps tx low during data).
      wr(A_BAUD, 32'd15, e);
      wr(A_CTRL, 32'h1, e);
      wr(A_TXD, 32'h00, w);
      tick(30);
      rd(A_STAT, 32'h05, "midframe_status_busy");
      chk("midframe_tx_low", tx, 1'b0);
      reset = 1'b0;
      tick(1);
      chk("reset_tx_next_cycle", tx, 1'b1);
      tick(2);
      reset = 1'b1;
      rd(A_STAT, 32'h01, "post_reset_status");
      rd(A_BAUD, 32'h0F, "post_reset_baud");
      rd(A_CTRL, 32'h00, "post_reset_ctrl");
      chk("post_reset_irq", IRQ, 1'b0);
      mon_en = 1'b1;

      // DIV=0, 0xA5: tx 0,1,0,1,0,0,1,0,1,1 from the pop edge.
      wr(A_BAUD, 32'd0, e);
      wr(A_CTRL, 32'h1, e);
      wr(A_TXD, 32'hA5, w);
      fq.push_back(mk(8'hA5, 1'b0, 1, NB, 1, w + 1, 1'b0));
      drain(100);
      chk("done_no_im_irq", IRQ, 1'b0);
      rd(A_STAT, 32'h11, "status_done");
      wr(A_STAT, 32'h0, e);
      rd(A_STAT, 32'h01, "status_done_cleared");

      // FIFO fill with EN=0, overflow, then back-to-back drain.
      wr(A_CTRL, 32'h0, e);
      wr(A_TXD, 32'h11, e);
      wr(A_TXD, 32'h12, e);
      rd(A_STAT, 32'h40, "status_count2");
      wr(A_TXD, 32'h13, e);
      wr(A_TXD, 32'h14, e);
      wr(A_TXD, 32'h15, e);
      rd(A_STAT, 32'h8A, "status_full_ovf");
      wr(A_CTRL, 32'h1, w);
      fq.push_back(mk(8'h11, 1'b0, 1, NB, 1, w + 1, 1'b0));
      fq.push_back(mk(8'h12, 1'b0, 1, NB, 1, -1, 1'b1));
      fq.push_back(mk(8'h13, 1'b0, 1, NB, 1, -1, 1'b1));
      fq.push_back(mk(8'h14, 1'b0, 1, NB, 1, -1, 1'b1));
      drain(200);
      rd(A_STAT, 32'h19, "status_after_burst");
      wr(A_STAT, 32'h0, e);
      rd(A_STAT, 32'h01, "status_ovf_cleared");

      // IRQ timing: DIV=3, IM=1.
      wr(A_BAUD, 32'd3, e);
      wr(A_CTRL, 32'h3, e);
      wr(A_TXD, 32'h3C, w);
      fq.push_back(mk(8'h3C, 1'b0, 4, NB, 4, w + 1, 1'b0));
      chk("irq_low_at_push", IRQ, 1'b0);
      e = -1;
      for (int i = 0; i < 200; i++) begin
         if (IRQ === 1'b1) begin
            e = cyc;
            break;
         end
         tick(1);
      end
      chk("irq_rise_cycle", e, w + NB * 4 + 2);
      wr(A_STAT, 32'h0, e);
      tick(1);
      chk("irq_cleared", IRQ, 1'b0);
      drain(100);

      // Mid-DATA BAUD 3 -> 1: bits 0..3 take 4 cycles, later bits 2.
      wr(A_CTRL, 32'h1, e);
      wr(A_TXD, 32'h96, w);
      fq.push_back(mk(8'h96, 1'b0, 4, 4, 2, w + 1, 1'b0));
      tick(13);
      wr(A_BAUD, 32'd1, e);
      drain(200);
      wr(A_BAUD, 32'd0, e);

`ifdef UART_TX_PARITY_EN
      // 0x07 has three ones: parity 1 with PODD=0, 0 with PODD=1.
      wr(A_CTRL, 32'h1, e);
      wr(A_TXD, 32'h07, w);
      fq.push_back(mk(8'h07, 1'b0, 1, NB, 1, w + 1, 1'b0));
      drain(100);
      wr(A_CTRL, 32'h5, e);
      wr(A_TXD, 32'h07, w);
      fq.push_back(mk(8'h07, 1'b1, 1, NB, 1, w + 1, 1'b0));
      drain(100);
`endif

      tick(5);
      chk("final_tx_idle", tx, 1'b1);
      chk("final_rd_queue_empty", rq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
